seq_adder: RTL
==============

SEQ_ADDER -- requirements
Module: seq_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand/result width in bits.
REQ-002 SHALL have parameter DIGIT, default 8: bits added per clock; WIDTH SHALL be an integer multiple of DIGIT (NUM = WIDTH/DIGIT).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port start  input  1  request; sampled only when not busy.
REQ-006 SHALL have port sub  input  1  1 = subtract (a - b), 0 = add (a + b + cin).
REQ-007 SHALL have ports a, b  input  WIDTH  operands.
REQ-008 SHALL have port cin  input  1  carry-in for add; ignored when sub = 1.
REQ-009 SHALL have port busy  output  1  operation in progress.
REQ-010 SHALL have port done  output  1  one-cycle completion pulse.
REQ-011 SHALL have port sum  output  WIDTH  result.
REQ-012 SHALL have port cout  output  1  carry out of MSB (sub: 1 = no borrow).
REQ-013 SHALL have port ovf  output  1  two's-complement overflow.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, DONE.
REQ-015 IDLE or DONE with start = 1 at an edge SHALL latch a, b (b inverted if sub), carry = sub ? 1 : cin, digit index 0, and enter RUN.
REQ-016 Each RUN edge SHALL add one DIGIT-bit slice, LSB slice first, propagating carry to the next slice.
REQ-017 After the NUM-th slice edge, state SHALL be DONE; sum, cout, ovf SHALL update at that same edge only.
REQ-018 done SHALL be high exactly during DONE, i.e. for one cycle beginning NUM edges after the edge sampling start.
REQ-019 busy SHALL be high exactly during RUN.
REQ-020 DONE with start = 0 SHALL return to IDLE at the next edge.
REQ-021 start while busy SHALL be ignored; latched operands SHALL be unaffected by input changes during RUN.
REQ-022 start in DONE SHALL be accepted (back-to-back); sum/cout/ovf SHALL hold until the next completion.
REQ-023 ovf SHALL equal carry-into-MSB XOR cout of the final slice.
REQ-024 DIGIT = WIDTH SHALL yield a single RUN cycle; result SHALL equal the WIDTH-bit modular sum.

Reset
REQ-025 rst = 1 at an edge SHALL force IDLE, busy = 0, done = 0, sum = 0, cout = 0, ovf = 0, from any state.
REQ-026 rst during RUN SHALL abort the operation with no done pulse; rst SHALL take priority over start.

Configuration
REQ-027 With SEQ_ADDER_SUB_EN defined, sub SHALL behave per REQ-006/015.
REQ-028 Without SEQ_ADDER_SUB_EN, sub SHALL be ignored, the operation SHALL always be a + b + cin, and no inversion logic SHALL be synthesised.

Structure
REQ-029 A shared package seq_adder_pkg SHALL hold the FSM state encoding constants and the default WIDTH/DIGIT values.
REQ-030 The slice adder SHALL be a sub-module digit_adder (DIGIT-bit ripple-carry of single-bit full-adder cells, outputs slice sum, carry-out, carry into slice MSB).

Verification (WIDTH = 32, DIGIT = 8, SEQ_ADDER_SUB_EN defined unless stated)
REQ-031 a = 0xFFFFFFFF, b = 0x00000001, cin = 0, sub = 0 -> done 4 edges after start, sum = 0x00000000, cout = 1, ovf = 0.
REQ-032 a = 0x7FFFFFFF, b = 0x00000001, sub = 0 -> sum = 0x80000000, cout = 0, ovf = 1.
REQ-033 a = 5, b = 7, sub = 1, cin = 1 -> sum = 0xFFFFFFFE, cout = 0, ovf = 0.
REQ-034 Start (1 + 2), re-pulse start with a = 0xFF at RUN cycle 2, then start (3 + 4) in DONE cycle -> sum = 3 then sum = 7, done pulses 5 cycles apart, second result unaffected by ignored start.
REQ-035 rst asserted at RUN cycle 2 -> next cycle IDLE, all outputs 0, no done pulse.
REQ-036 SEQ_ADDER_SUB_EN undefined, a = 5, b = 7, sub = 1, cin = 0 -> sum = 0x0000000C, cout = 0.

Source files
------------

// File: rtl/seq_adder_pkg.sv
// seq_adder_pkg: shared definitions for the digit-serial adder.
//   - DEF_WIDTH / DEF_DIGIT : default operand width and bits added per clock
//   - state_e               : FSM state encoding (IDLE, RUN, DONE)
package seq_adder_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_DIGIT = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/seq_adder_digit.sv
// digit_adder: DIGIT-bit ripple-carry adder built from single-bit full-adder
// cells. Used once per clock by seq_adder to add one operand slice.
// Ports:
//   a_i, b_i  slice operands
//   c_i       carry into bit 0
//   s_o       slice sum
//   co_o      carry out of the slice MSB
//   cmsb_o    carry into the slice MSB (for signed overflow detection)
module digit_adder #(
  parameter int DIGIT = 8
) (
  input  logic [DIGIT-1:0] a_i,
  input  logic [DIGIT-1:0] b_i,
  input  logic             c_i,
  output logic [DIGIT-1:0] s_o,
  output logic             co_o,
  output logic             cmsb_o
);

  logic [DIGIT:0] c;

  assign c[0] = c_i;

  for (genvar i = 0; i < DIGIT; i++) begin : g_fa
    assign s_o[i]   = a_i[i] ^ b_i[i] ^ c[i];
    assign c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
  end

  assign co_o   = c[DIGIT];
  assign cmsb_o = c[DIGIT-1];

endmodule

// File: rtl/seq_adder.sv
// seq_adder: digit-serial adder/subtractor. Adds DIGIT bits per clock, LSB
// slice first, finishing WIDTH/DIGIT clocks after start is accepted.
// Optional feature macro: SEQ_ADDER_SUB_EN enables subtraction via 'sub';
// without it 'sub' is ignored and no inversion logic exists.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start           request (sampled in IDLE/DONE only)
//   sub, a, b, cin  operation select, operands, carry-in
//   busy            high while RUN
//   done            one-cycle pulse in DONE
//   sum, cout, ovf  result, carry out of MSB, signed overflow
module seq_adder
  import seq_adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DIGIT = DEF_DIGIT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NUM = WIDTH / DIGIT;
  localparam int IW  = (NUM > 1) ? $clog2(NUM) : 1;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             c_q, c_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  // Operand conditioning at latch time: subtraction is a + ~b + 1.
  logic [WIDTH-1:0] b_in;
  logic             c_in;
`ifdef SEQ_ADDER_SUB_EN
  assign b_in = sub ? ~b : b;
  assign c_in = sub | cin;
`else
  logic unused_sub;
  assign unused_sub = sub;
  assign b_in       = b;
  assign c_in       = cin;
`endif

  logic [DIGIT-1:0] sl_a, sl_b, sl_s;
  logic             sl_co, sl_cmsb;
  logic             last;

  assign sl_a = a_q[idx_q*DIGIT +: DIGIT];
  assign sl_b = b_q[idx_q*DIGIT +: DIGIT];
  assign last = (idx_q == IW'(NUM - 1));

  digit_adder #(.DIGIT(DIGIT)) u_digit (
    .a_i    (sl_a),
    .b_i    (sl_b),
    .c_i    (c_q),
    .s_o    (sl_s),
    .co_o   (sl_co),
    .cmsb_o (sl_cmsb)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    c_d     = c_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_d     = a;
          b_d     = b_in;
          c_d     = c_in;
          idx_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        acc_d[idx_q*DIGIT +: DIGIT] = sl_s;
        c_d = sl_co;
        if (last) begin
          // Visible result only changes here, so it holds across a
          // back-to-back operation until that one completes.
          sum_d   = acc_d;
          cout_d  = sl_co;
          ovf_d   = sl_cmsb ^ sl_co;
          state_d = DONE;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      c_q     <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      c_q     <= c_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule
